// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches rising edges on peripheral lines,
// arbitrates by fixed priority and drives a single masked IRQ towards the CPU.
module irq_controller #(
  parameter int          NSRC = 4,
  parameter logic [31:0] BASE = 32'h40000020
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            pc31,
  input  logic            ack,
  input  logic            advance,
  input  logic [31:0]     address,
  input  logic            read_enable,
  input  logic            write_enable,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic            irq
);

  logic [NSRC-1:0] ienable_reg, ienable_next;
  logic [NSRC-1:0] ipend_reg, ipend_next;
  logic [NSRC-1:0] src_q_reg;
  logic            gie_reg, gie_next;
  logic            insvc_reg, insvc_next;
  logic            cause_valid_reg, cause_valid_next;
  logic [3:0]      cause_id_reg, cause_id_next;

  logic [NSRC-1:0] rise, clr, cand;
  logic [3:0]      winner;
  logic [31:0]     offset;
  logic [1:0]      sel;
  logic            in_window, wr_en, w1c, take;
  logic            unused_bits;

  // Window decode works for any word-aligned BASE, not only 16-byte aligned ones.
  assign offset    = {address[31:2], 2'b00} - BASE;
  assign in_window = (offset[31:4] == 28'd0);
  assign sel       = offset[3:2];
  assign wr_en     = write_enable & advance & in_window;
  assign w1c       = wr_en & (sel == 2'd1);

  assign cand = ipend_reg & ienable_reg;
  assign irq  = gie_reg & ~insvc_reg & ~pc31 & (|cand);
  assign take = ack & advance & irq;

  always_comb begin
    winner = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) winner = 4'(i);
    end
  end

  // A new edge on a bit always survives a same-cycle clear.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_pend
      assign rise[gi]       = src[gi] & ~src_q_reg[gi];
      assign clr[gi]        = (take & (winner == 4'(gi))) | (w1c & writedata[gi]);
      assign ipend_next[gi] = rise[gi] | (ipend_reg[gi] & ~clr[gi]);
    end
  endgenerate

  always_comb begin
    ienable_next     = ienable_reg;
    gie_next         = gie_reg;
    insvc_next       = insvc_reg;
    cause_valid_next = cause_valid_reg;
    cause_id_next    = cause_id_reg;
    if (wr_en && sel == 2'd0) ienable_next = writedata[NSRC-1:0];
    if (wr_en && sel == 2'd3) begin
      gie_next = writedata[0];
      if (!writedata[1]) begin
        insvc_next       = 1'b0;
        cause_valid_next = 1'b0;
      end
    end
    if (take) begin
      cause_valid_next = 1'b1;
      cause_id_next    = winner;
      insvc_next       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ienable_reg     <= '0;
      ipend_reg       <= '0;
      src_q_reg       <= '0;
      gie_reg         <= 1'b0;
      insvc_reg       <= 1'b0;
      cause_valid_reg <= 1'b0;
      cause_id_reg    <= 4'd0;
    end else begin
      ienable_reg     <= ienable_next;
      ipend_reg       <= ipend_next;
      src_q_reg       <= src;
      gie_reg         <= gie_next;
      insvc_reg       <= insvc_next;
      cause_valid_reg <= cause_valid_next;
      cause_id_reg    <= cause_id_next;
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (read_enable && in_window) begin
      case (sel)
        2'd0:    readdata[NSRC-1:0] = ienable_reg;
        2'd1:    readdata[NSRC-1:0] = ipend_reg;
        2'd2:    readdata = {cause_valid_reg, 27'd0, cause_id_reg};
        default: readdata = {30'd0, insvc_reg, gie_reg};
      endcase
    end
  end

  assign unused_bits = &{1'b0, writedata, address[1:0], offset[1:0]};

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed scenarios plus random traffic
// checked against an array-based behavioural model.
module tb_irq_controller;

  localparam int          NSRC = 4;
  localparam logic [31:0] BASE = 32'h40000020;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            pc31, ack, advance;
  logic [31:0]     address;
  logic            read_enable, write_enable;
  logic [31:0]     writedata;
  logic [31:0]     readdata;
  logic            irq;

  irq_controller #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .pc31(pc31), .ack(ack),
    .advance(advance), .address(address), .read_enable(read_enable),
    .write_enable(write_enable), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  bit [NSRC-1:0] m_en, m_pend, m_prev;
  bit            m_gie, m_insvc, m_cv;
  int            m_id;

  // Scoreboard queues, one entry per observed cycle
  bit          exp_irq_q[$];
  bit          chk_rd_q[$];
  logic [31:0] exp_rd_q[$];
  string       tag_q[$];

  int          checks = 0;
  int          passes = 0;
  string       tag;
  bit          use_const;
  logic [31:0] const_val;

  function automatic void model_reset();
    m_en = '0; m_pend = '0; m_prev = '0;
    m_gie = 0; m_insvc = 0; m_cv = 0; m_id = 0;
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < NSRC; i++) if (m_pend[i] && m_en[i]) return i;
    return -1;
  endfunction

  function automatic bit m_irq();
    return m_gie && !m_insvc && !pc31 && (m_winner() >= 0);
  endfunction

  function automatic int m_reg(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w >= BASE && w < BASE + 32'd16) return int'((w - BASE) >> 2);
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (m_reg(a))
      0:       return 32'(m_en);
      1:       return 32'(m_pend);
      2:       return (m_cv ? 32'h8000_0000 : 32'h0) | 32'(m_id);
      3:       return {30'd0, m_insvc, m_gie};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_update();
    int w, rg;
    bit tk;
    w  = m_winner();
    tk = ack && advance && m_irq();
    rg = (write_enable && advance) ? m_reg(address) : -1;
    for (int i = 0; i < NSRC; i++) begin
      bit clear_bit;
      clear_bit = (tk && i == w) || (rg == 1 && writedata[i]);
      m_pend[i] = (src[i] && !m_prev[i]) || (m_pend[i] && !clear_bit);
    end
    if (rg == 0) m_en = writedata[NSRC-1:0];
    if (rg == 3) begin
      m_gie = writedata[0];
      if (!writedata[1]) begin m_insvc = 0; m_cv = 0; end
    end
    if (tk) begin m_cv = 1; m_id = w; m_insvc = 1; end
    m_prev = src;
  endfunction

  task automatic step();
    if (!reset) model_reset();
    exp_irq_q.push_back(m_irq());
    chk_rd_q.push_back(read_enable);
    exp_rd_q.push_back(read_enable ? (use_const ? const_val : m_read(address)) : 32'd0);
    tag_q.push_back(tag);
    @(posedge clk);
    if (!reset) model_reset();
    else model_update();
    #1;
    read_enable = 0; write_enable = 0; ack = 0; advance = 1; use_const = 0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp, input string t);
    address = BASE + 32'(idx * 4); read_enable = 1;
    use_const = 1; const_val = exp; tag = t;
    step();
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input string t);
    address = BASE + 32'(idx * 4); write_enable = 1; writedata = d; tag = t;
    step();
  endtask

  task automatic sstep(input logic [NSRC-1:0] s, input string t);
    src = s; tag = t;
    step();
  endtask

  task automatic take(input string t);
    ack = 1; tag = t;
    step();
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle
  always @(negedge clk) begin : monitor
    bit          e_irq, c_rd;
    logic [31:0] e_rd;
    string       t;
    if (exp_irq_q.size() > 0) begin
      e_irq = exp_irq_q.pop_front();
      c_rd  = chk_rd_q.pop_front();
      e_rd  = exp_rd_q.pop_front();
      t     = tag_q.pop_front();
      checks++;
      if (irq === e_irq) passes++;
      else $display("FAIL %s irq: got %0b expected %0b", t, irq, e_irq);
      if (c_rd) begin
        checks++;
        if (readdata === e_rd) passes++;
        else $display("FAIL %s readdata: got %h expected %h", t, readdata, e_rd);
      end
    end
  end

  initial begin
    reset = 0; src = '0; pc31 = 0; ack = 0; advance = 1;
    address = '0; read_enable = 0; write_enable = 0; writedata = '0;
    use_const = 0; const_val = '0; tag = "init";
    model_reset();
    @(posedge clk); #1;

    // Reset state
    rd(0, 32'h0, "rst_ienable");
    rd(1, 32'h0, "rst_ipend");
    rd(2, 32'h0, "rst_icause");
    rd(3, 32'h0, "rst_ictrl");
    reset = 1;

    // Basic single-source flow
    wr(0, 32'h3, "en3");
    wr(3, 32'h1, "gie");
    sstep(4'h2, "src1_hi");
    sstep(4'h0, "src1_lo");
    rd(1, 32'h2, "ipend_src1");
    take("take1");
    rd(2, 32'h8000_0001, "icause_1");
    rd(1, 32'h0, "ipend_after_take");
    wr(3, 32'h1, "eoi1");

    // Simultaneous sources: priority to lower index
    wr(0, 32'hF, "enF");
    sstep(4'h9, "src03_hi");
    sstep(4'h0, "src03_lo");
    take("take_0");
    rd(2, 32'h8000_0000, "icause_0");
    wr(3, 32'h1, "eoi_0");
    take("take_3");
    rd(2, 32'h8000_0003, "icause_3");
    wr(3, 32'h1, "eoi_3");
    rd(1, 32'h0, "ipend_empty");

    // Masked source, late enable, W1C
    wr(0, 32'h0, "en0");
    sstep(4'h1, "mask_hi");
    sstep(4'h0, "mask_lo");
    rd(1, 32'h1, "ipend_masked");
    wr(0, 32'h1, "en1");
    rd(3, 32'h1, "ictrl_gie");
    wr(1, 32'h1, "w1c");
    rd(1, 32'h0, "ipend_w1c");

    // Edge coinciding with take of the same source
    wr(0, 32'h4, "en4");
    sstep(4'h4, "s2_hi");
    sstep(4'h0, "s2_lo");
    src = 4'h4; ack = 1; tag = "take2_edge"; step();
    src = 4'h0;
    rd(1, 32'h4, "ipend_edge_kept");
    rd(2, 32'h8000_0002, "icause_2");
    rd(3, 32'h3, "ictrl_insvc");
    wr(3, 32'h1, "eoi_2");
    tag = "reassert"; step();
    take("take2b");
    wr(3, 32'h1, "eoi_2b");

    // Stalls and kernel-mode masking
    sstep(4'h4, "s2b_hi");
    sstep(4'h0, "s2b_lo");
    ack = 1; advance = 0; tag = "ack_stall"; step();
    rd(2, 32'h2, "icause_stall");
    rd(1, 32'h4, "ipend_stall");
    address = BASE; write_enable = 1; writedata = 32'h0; advance = 0;
    tag = "wr_stall"; step();
    rd(0, 32'h4, "ienable_stall");
    pc31 = 1;
    rd(3, 32'h1, "pc31_high");
    pc31 = 0;

    // Asynchronous reset mid-service
    wr(0, 32'hF, "enF_b");
    sstep(4'hF, "all_hi");
    sstep(4'h0, "all_lo");
    take("take_b");
    sstep(4'h1, "s0_again");
    src = 4'h0;
    rd(1, 32'hF, "ipend_full");
    rd(3, 32'h3, "insvc_set");
    #2 reset = 0;
    rd(2, 32'h0, "async_icause");
    rd(1, 32'h0, "async_ipend");
    rd(0, 32'h0, "async_ienable");
    rd(3, 32'h0, "async_ictrl");
    reset = 1;

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) src = NSRC'($urandom);
      pc31    = ($urandom_range(0, 7) == 0);
      advance = ($urandom_range(0, 3) != 0);
      ack     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) address = BASE - 32'd4;
      else address = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        1: read_enable = 1;
        2: begin
          write_enable = 1;
          writedata = $urandom;
          if ($urandom_range(0, 1) == 0) writedata[1] = 1'b1;
          if (m_reg(address) == 3) ack = 0;
        end
        default: ;
      endcase
      tag = "rand";
      step();
    end

    @(negedge clk); #1;
    checks++;
    if (exp_irq_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_irq_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller that drives the CPU's `IRQ` input, currently tied low. It latches rising edges from up to `NSRC` peripheral interrupt lines (timer, UART RX, UART TX, …) and arbitrates them by fixed priority. It holds a cause register that the exception handler at `XADR` reads, and it keeps the request masked until the handler signals end-of-interrupt. It sits beside `DataMemory` on the data bus, clocked by the divided CPU clock.

## Interface
- `NSRC`, 4: number of interrupt sources, 1..16.
- `BASE`, 32'h40000020: byte address of register 0; window is `BASE`..`BASE+12`.
- `clk` input 1: divided CPU clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `src` input NSRC: level interrupt lines from peripherals, synchronous to `clk`.
- `pc31` input 1: `PC[31]` (kernel mode); suppresses `irq` while 1.
- `ack` input 1: CPU is taking the interrupt this cycle (control selected `XADR`).
- `advance` input 1: CPU `if_continue`; `ack` and bus writes count only when 1.
- `address` input 32: data-bus address (`ALU_OUT`).
- `read_enable` input 1: bus read strobe.
- `write_enable` input 1: bus write strobe.
- `writedata` input 32: bus write data.
- `readdata` output 32: combinational read data; 0 when not selected.
- `irq` output 1: interrupt request to `Control`.

## Operation
- Registers (offsets from `BASE`, word-aligned; `address[1:0]` ignored):
  - 0x0 IENABLE: R/W, bits [NSRC-1:0] per-source mask; upper bits read 0.
  - 0x4 IPEND: R; write-1-to-clear per bit; writing 0 has no effect.
  - 0x8 ICAUSE: R only; [31] valid, [3:0] in-service source id, other bits 0.
  - 0xC ICTRL: bit0 GIE is R/W. Bit1 INSVC reads the in-service flag; writing 0 clears it (EOI), writing 1 is ignored.
- Edge detect:
  - `src_q` holds the previous `src` sample.
  - `rise = src & ~src_q` sets the corresponding IPEND bit.
  - Pending bits are captured regardless of IENABLE and GIE.
- Arbitration:
  - `cand = IPEND & IENABLE`.
  - Winner is the lowest-index set bit of `cand`; index 0 has highest priority.
- `irq = GIE & ~INSVC & ~pc31 & |cand`. This is combinational from registered state; it is not registered again.
- Take (`ack & advance & irq` at a clock edge):
  - ICAUSE ← {1, winner}.
  - INSVC ← 1.
  - IPEND[winner] ← 0.
- `ack` while `irq`=0 is ignored; no state changes.
- EOI: a write to ICTRL with bit1=0 clears INSVC and ICAUSE[31]. ICAUSE[3:0] keeps its value. A GIE write in the same access applies too.
- No nesting: while INSVC=1, `irq` stays 0 regardless of new pending bits.
- Priority of simultaneous events on one IPEND bit, same edge: set from `rise` beats clear from take or W1C. Take clear and W1C combined are an OR.
- Bus writes are qualified by `write_enable & advance & address in window`. Reads decode the same window with `read_enable`.
- `readdata` = selected register when `read_enable` and address in window, else 0.

## Timing
- Reset (`reset`=0, asynchronous) clears, on every output and register:
  - IENABLE = 0, IPEND = 0, ICAUSE = 0, GIE = 0, INSVC = 0, `src_q` = 0.
  - Result: `irq` = 0, `readdata` = 0.
  - A `src` held high through reset release produces one edge on the first clock.
- Source latency: `src[i]` rises before edge k → IPEND[i]=1 after edge k. `irq`=1 in the cycle after edge k if enabled and GIE=1.
- Take: `irq` falls after the take edge. The handler can read ICAUSE at the first `XADR` instruction.
- EOI: `irq` can reassert in the cycle after the EOI write edge if `cand` is non-zero and `pc31`=0.
- `irq` follows `pc31` combinationally; it stays low while the handler runs in kernel mode even after EOI.
- A stalled cycle (`advance`=0) still samples `src` edges but commits no take and no writes.
- A reset mid-service drops INSVC and all pending events; nothing is replayed.

## Test plan
- Reset, then write IENABLE=0x3, GIE=1, and pulse `src[1]` → IPEND reads 0x2 and `irq`=1 one edge later. Take with `ack` → ICAUSE=0x80000001, `irq`=0, IPEND=0.
- Raise `src[3]` and `src[0]` on the same edge with IENABLE=0xF → first take gives ICAUSE id 0. After EOI, the second take gives id 3.
- Source masked (IENABLE=0) and pulsed → IPEND=0x1, `irq`=0. Then set IENABLE=0x1 → `irq`=1 the next cycle. W1C 0x1 to IPEND → `irq`=0.
- `src[2]` edge coincides with the take of source 2 → IPEND[2] remains 1. After EOI with `pc31`=0, `irq` reasserts.
- `ack` with `advance`=0, and a write with `advance`=0 → no state change. `pc31`=1 with pending enabled → `irq`=0.
- Assert `reset`=0 asynchronously mid-cycle while INSVC=1 and IPEND=0xF → all registers read 0 and `irq`=0 immediately, without a clock edge.
